// File: rtl/dca_matrix_store_scheduler_pkg.sv
// Shared state encoding and size helpers for the DCA matrix store scheduler.
package dca_matrix_store_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TILE = 3'd1,
    REQ       = 3'd2,
    ISSUE     = 3'd3,
    DRAIN     = 3'd4
  } sched_state_e;

  // Bytes covered by one tensor row of a tile.
  function automatic int unsigned row_bytes(input int unsigned num_col,
                                            input int unsigned bw_scalar);
    return (num_col * bw_scalar) / 8;
  endfunction

endpackage

// File: rtl/dca_matrix_store_scheduler_if.sv
// Job config, tile-ready, mover and store-DMA command signals of the store scheduler.
interface dca_matrix_store_scheduler_if #(
  parameter int unsigned BW_ADDR     = 32,
  parameter int unsigned BW_TILE_IDX = 8
);
  logic                   cfg_valid;
  logic                   cfg_ready;
  logic [BW_ADDR-1:0]     cfg_base_addr;
  logic [BW_ADDR-1:0]     cfg_row_stride;
  logic [BW_TILE_IDX-1:0] cfg_num_tile_row;
  logic [BW_TILE_IDX-1:0] cfg_num_tile_col;
  logic                   tile_avail_valid;
  logic                   tile_avail_ready;
  logic                   storereg_wready;
  logic                   storereg_wrequest;
  logic                   wcmd_valid;
  logic                   wcmd_ready;
  logic [BW_ADDR-1:0]     wcmd_addr;
  logic                   wcmd_last;

  // Scheduler side.
  modport master (
    input  cfg_valid, cfg_base_addr, cfg_row_stride, cfg_num_tile_row, cfg_num_tile_col,
    input  tile_avail_valid, storereg_wready, wcmd_ready,
    output cfg_ready, tile_avail_ready, storereg_wrequest, wcmd_valid, wcmd_addr, wcmd_last
  );

  // Control registers, compute engine, mover and DMA side.
  modport slave (
    output cfg_valid, cfg_base_addr, cfg_row_stride, cfg_num_tile_row, cfg_num_tile_col,
    output tile_avail_valid, storereg_wready, wcmd_ready,
    input  cfg_ready, tile_avail_ready, storereg_wrequest, wcmd_valid, wcmd_addr, wcmd_last
  );
endinterface

// File: rtl/dca_matrix_store_addr_gen.sv
// Incremental row-address generator: tile-row base, tile-column base and row address,
// advanced with adders only.
module dca_matrix_store_addr_gen #(
  parameter int unsigned BW_ADDR   = 32,
  parameter int unsigned ROW_BYTES = 16,
  parameter int unsigned ROW_SHIFT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               next_row,
  input  logic               next_tile_col,
  input  logic               next_tile_row,
  input  logic [BW_ADDR-1:0] base_addr,
  input  logic [BW_ADDR-1:0] row_stride,
  output logic [BW_ADDR-1:0] row_addr
);

  localparam logic [BW_ADDR-1:0] COL_STEP = BW_ADDR'(ROW_BYTES);

  logic [BW_ADDR-1:0] stride_q;
  logic [BW_ADDR-1:0] tile_step_q;
  logic [BW_ADDR-1:0] row_base_q;
  logic [BW_ADDR-1:0] col_base_q;
  logic [BW_ADDR-1:0] col_base_nx;
  logic [BW_ADDR-1:0] row_base_nx;

  assign col_base_nx = col_base_q + COL_STEP;
  assign row_base_nx = row_base_q + tile_step_q;

  // A new tile starts its row address at the new tile-column base in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      stride_q    <= '0;
      tile_step_q <= '0;
      row_base_q  <= '0;
      col_base_q  <= '0;
      row_addr    <= '0;
    end else if (load) begin
      stride_q    <= row_stride;
      tile_step_q <= row_stride << ROW_SHIFT;
      row_base_q  <= base_addr;
      col_base_q  <= base_addr;
      row_addr    <= base_addr;
    end else if (next_tile_row) begin
      row_base_q  <= row_base_nx;
      col_base_q  <= row_base_nx;
      row_addr    <= row_base_nx;
    end else if (next_tile_col) begin
      col_base_q  <= col_base_nx;
      row_addr    <= col_base_nx;
    end else if (next_row) begin
      row_addr    <= row_addr + stride_q;
    end
  end

endmodule

// File: rtl/dca_matrix_store_scheduler.sv
// Sequences tile-by-tile storage of the output matrix: waits for each tile, starts the
// mover, issues one store command per row, then waits for the mover to drain.
module dca_matrix_store_scheduler
  import dca_matrix_store_scheduler_pkg::*;
#(
  parameter int unsigned MATRIX_SIZE_PARA = 4,
  parameter int unsigned BW_TENSOR_SCALAR = 32,
  parameter int unsigned BW_ADDR          = 32,
  parameter int unsigned BW_TILE_IDX      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic busy,
  output logic done,
  dca_matrix_store_scheduler_if.master bus
);

  localparam int unsigned MATRIX_NUM_ROW = MATRIX_SIZE_PARA;
  localparam int unsigned MATRIX_NUM_COL = MATRIX_SIZE_PARA;
  localparam int unsigned ROW_BYTES      = row_bytes(MATRIX_NUM_COL, BW_TENSOR_SCALAR);
  localparam int unsigned ROW_SHIFT      = $clog2(MATRIX_NUM_ROW);
  localparam int unsigned RW             = (MATRIX_NUM_ROW > 1) ? ROW_SHIFT : 1;
  localparam logic [RW-1:0] LAST_ROW     = RW'(MATRIX_NUM_ROW - 1);

  sched_state_e state;
  sched_state_e state_nx;

  logic                   sync_rst;
  logic [BW_TILE_IDX-1:0] tr;
  logic [BW_TILE_IDX-1:0] tc;
  logic [BW_TILE_IDX-1:0] ntr;
  logic [BW_TILE_IDX-1:0] ntc;
  logic [RW-1:0]          r;
  logic                   zero_done_q;

  logic cfg_fire;
  logic avail_fire;
  logic req_fire;
  logic wcmd_fire;
  logic drain_fire;
  logic zero_job;
  logic last_row;
  logic last_col;
  logic last_tile;

  logic load;
  logic next_row;
  logic next_tile_col;
  logic next_tile_row;

  assign sync_rst = rst | clear;

  assign bus.cfg_ready         = enable && (state == IDLE);
  assign bus.tile_avail_ready  = enable && (state == WAIT_TILE);
  assign bus.storereg_wrequest = enable && (state == REQ) && bus.storereg_wready;
  assign bus.wcmd_valid        = enable && (state == ISSUE);
  assign bus.wcmd_last         = (state == ISSUE) && last_row;
  assign busy                  = (state != IDLE);

  assign cfg_fire   = bus.cfg_valid && bus.cfg_ready;
  assign avail_fire = bus.tile_avail_valid && bus.tile_avail_ready;
  assign req_fire   = bus.storereg_wrequest;
  assign wcmd_fire  = bus.wcmd_valid && bus.wcmd_ready;
  assign drain_fire = enable && (state == DRAIN) && bus.storereg_wready;

  assign zero_job  = (bus.cfg_num_tile_row == '0) || (bus.cfg_num_tile_col == '0);
  assign last_row  = (r == LAST_ROW);
  assign last_col  = (tc == ntc - BW_TILE_IDX'(1));
  assign last_tile = last_col && (tr == ntr - BW_TILE_IDX'(1));

  // Zero-tile jobs report done one cycle after acceptance; real jobs on the final drain.
  assign done = enable && (zero_done_q || (drain_fire && last_tile));

  always_comb begin
    state_nx      = state;
    load          = 1'b0;
    next_row      = 1'b0;
    next_tile_col = 1'b0;
    next_tile_row = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_fire) begin
          load = 1'b1;
          if (!zero_job) state_nx = WAIT_TILE;
        end
      end
      WAIT_TILE: begin
        if (avail_fire) state_nx = REQ;
      end
      REQ: begin
        if (req_fire) state_nx = ISSUE;
      end
      ISSUE: begin
        if (wcmd_fire) begin
          next_row = 1'b1;
          if (last_row) state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_fire) begin
          next_tile_row = last_col;
          next_tile_col = !last_col;
          state_nx      = last_tile ? IDLE : WAIT_TILE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state       <= IDLE;
      tr          <= '0;
      tc          <= '0;
      ntr         <= '0;
      ntc         <= '0;
      r           <= '0;
      zero_done_q <= 1'b0;
    end else begin
      if (enable) state <= state_nx;
      if (cfg_fire) begin
        ntr <= bus.cfg_num_tile_row;
        ntc <= bus.cfg_num_tile_col;
        tr  <= '0;
        tc  <= '0;
      end
      if (req_fire) r <= '0;
      else if (wcmd_fire) r <= r + RW'(1);
      if (drain_fire) begin
        if (last_col) begin
          tc <= '0;
          tr <= tr + BW_TILE_IDX'(1);
        end else begin
          tc <= tc + BW_TILE_IDX'(1);
        end
      end
      if (cfg_fire && zero_job) zero_done_q <= 1'b1;
      else if (enable)          zero_done_q <= 1'b0;
    end
  end

  dca_matrix_store_addr_gen #(
    .BW_ADDR   (BW_ADDR),
    .ROW_BYTES (ROW_BYTES),
    .ROW_SHIFT (ROW_SHIFT)
  ) u_addr_gen (
    .clk           (clk),
    .rst           (sync_rst),
    .load          (load),
    .next_row      (next_row),
    .next_tile_col (next_tile_col),
    .next_tile_row (next_tile_row),
    .base_addr     (bus.cfg_base_addr),
    .row_stride    (bus.cfg_row_stride),
    .row_addr      (bus.wcmd_addr)
  );

endmodule
